instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - instruction prefetch FIFO between ROM and core; IFB_NOP_FILL_EN zeroes outputs on bubbles
module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter int          ROM_AW   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              rom_req_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       instr_pc_o,
    output logic              instr_valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       inflight_tag_q, inflight_tag_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       mem_data_q [DEPTH];
    logic [31:0]       mem_data_d [DEPTH];
    logic [31:0]       mem_pc_q   [DEPTH];
    logic [31:0]       mem_pc_d   [DEPTH];

    logic [CW:0]       occupancy;
    logic              fetch_en;
    logic              push;
    logic              pop;
    logic [1:0]        unused_redirect_lsbs;

    // The low address bits of a redirect target are dropped by word alignment.
    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // The in-flight request reserves a slot, so the FIFO can never overflow.
    assign occupancy     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign fetch_en      = (state_q != S_BOOT) && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    assign push          = inflight_q && !redirect_i && (state_q != S_FLUSH);
    assign pop           = (count_q != '0) && !stall_i && !redirect_i;

    assign rom_req_o     = fetch_en;
    assign rom_addr_o    = fetch_pc_q[ROM_AW+1:2];
    assign instr_valid_o = (count_q != '0);

    // Head-of-FIFO presentation; optional zero fill turns bubbles into NOPs.
    always_comb begin
`ifdef IFB_NOP_FILL_EN
        instr_o    = instr_valid_o ? mem_data_q[rd_ptr_q] : 32'h0;
        instr_pc_o = instr_valid_o ? mem_pc_q[rd_ptr_q]   : 32'h0;
`else
        instr_o    = mem_data_q[rd_ptr_q];
        instr_pc_o = mem_pc_q[rd_ptr_q];
`endif
    end

    // Next-state, fetch PC, in-flight tracking and FIFO bookkeeping.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        inflight_d     = fetch_en;
        inflight_tag_d = fetch_pc_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        mem_data_d     = mem_data_q;
        mem_pc_d       = mem_pc_q;

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = redirect_i ? S_FLUSH : S_RUN;
            S_FLUSH: state_d = redirect_i ? S_FLUSH : S_RUN;
            default: state_d = S_BOOT;
        endcase

        if (redirect_i) begin
            // Flush wins over everything: drop buffered and in-flight words.
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_en) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                mem_data_d[wr_ptr_q] = rom_data_i;
                mem_pc_d[wr_ptr_q]   = inflight_tag_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_BOOT;
            fetch_pc_q     <= RESET_PC;
            inflight_q     <= 1'b0;
            inflight_tag_q <= 32'h0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= 32'h0;
                mem_pc_q[i]   <= 32'h0;
            end
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            inflight_q     <= inflight_d;
            inflight_tag_q <= inflight_tag_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            mem_data_q     <= mem_data_d;
            mem_pc_q       <= mem_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - randomized bench for instr_fetch_buffer against a queue-based reference model
module tb_instr_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          ROM_AW   = 8;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk;
    logic              rst_n;
    logic              stall_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic              rom_req_o;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [31:0]       rom_data_i;
    logic [31:0]       instr_o;
    logic [31:0]       instr_pc_o;
    logic              instr_valid_o;

    int tests_run;
    int tests_failed;

    // reference model state
    bit          m_known;
    bit          m_booting;
    bit          m_fresh;
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_q[$];

    instr_fetch_buffer #(
        .DEPTH    (DEPTH),
        .ROM_AW   (ROM_AW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .rom_req_o     (rom_req_o),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM image: word i holds i+100
    function automatic logic [31:0] rom_val(input logic [ROM_AW-1:0] a);
        return 32'(a) + 32'd100;
    endfunction

    function automatic logic [ROM_AW-1:0] word_of(input logic [31:0] pc);
        return pc[ROM_AW+1:2];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic tick(input bit r, input bit s, input bit d, input logic [31:0] p);
        bit                exp_req;
        bit                req_seen;
        logic [ROM_AW-1:0] addr_seen;
        rst_n         = r;
        stall_i       = s;
        redirect_i    = d;
        redirect_pc_i = p;
        @(negedge clk);
        exp_req = !m_booting && !d && ((m_q.size() + int'(m_infl)) < DEPTH);
        if (m_known) begin
            check("rom_req", 32'(rom_req_o), 32'(exp_req));
            check("rom_addr", 32'(rom_addr_o), 32'(word_of(m_pc)));
            check("valid", 32'(instr_valid_o), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("instr_pc", instr_pc_o, m_q[0]);
                check("instr", instr_o, rom_val(word_of(m_q[0])));
            end else begin
`ifdef IFB_NOP_FILL_EN
                check("nop_instr", instr_o, 32'h0);
                check("nop_pc", instr_pc_o, 32'h0);
`else
                if (m_fresh) begin
                    check("rst_instr", instr_o, 32'h0);
                    check("rst_pc", instr_pc_o, 32'h0);
                end
`endif
            end
        end
        req_seen  = rom_req_o;
        addr_seen = rom_addr_o;
        @(posedge clk);
        if (!r) begin
            m_known   = 1'b1;
            m_booting = 1'b1;
            m_fresh   = 1'b1;
            m_pc      = RESET_PC;
            m_infl    = 1'b0;
            m_q.delete();
        end else if (m_known) begin
            if (d) begin
                m_q.delete();
                m_infl    = 1'b0;
                m_pc      = {p[31:2], 2'b00};
                m_booting = 1'b0;
            end else begin
                if (m_q.size() != 0 && !s) void'(m_q.pop_front());
                if (m_infl) begin
                    m_q.push_back(m_infl_pc);
                    m_fresh = 1'b0;
                end
                m_infl    = exp_req;
                m_infl_pc = m_pc;
                if (exp_req) m_pc = m_pc + 32'd4;
                m_booting = 1'b0;
            end
        end
        #1;
        rom_data_i = req_seen ? rom_val(addr_seen) : {16'hDEAD, 16'($urandom)};
    endtask

    initial begin
        logic [31:0] rpc;
        tests_run     = 0;
        tests_failed  = 0;
        m_known       = 1'b0;
        m_booting     = 1'b1;
        m_fresh       = 1'b1;
        m_pc          = RESET_PC;
        m_infl        = 1'b0;
        m_infl_pc     = 32'h0;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        rom_data_i    = 32'h0;
        @(posedge clk);
        #1;

        // reset, then free-running stream from RESET_PC
        repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (20) tick(1'b1, 1'b0, 1'b0, 32'h0);

        // long stall fills the FIFO, then release
        repeat (10) tick(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (12) tick(1'b1, 1'b0, 1'b0, 32'h0);

        // redirect to unaligned 0x43 while full
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h43);
        repeat (8) tick(1'b1, 1'b0, 1'b0, 32'h0);

        // back-to-back redirects: 0x20 must never be delivered
        tick(1'b1, 1'b0, 1'b1, 32'h20);
        tick(1'b1, 1'b0, 1'b1, 32'h80);
        repeat (8) tick(1'b1, 1'b0, 1'b0, 32'h0);

        // fetch PC wrap past 2^32
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);

        // one-cycle reset pulse during streaming
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            tick(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 19) == 0),
                 rpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
